// File: rtl/sseg_pkg.sv
// Shared constants and state type for the segment-chase bus monitor.
// Segment and anode codes are active-low, exactly as seen on the display nets.
package sseg_pkg;

    localparam logic [7:0] TOP  = 8'b10011100;
    localparam logic [7:0] BOT  = 8'b10100011;
    localparam logic [7:0] NONE = 8'hFF;

    localparam logic [7:0] AN0    = 8'hFE;
    localparam logic [7:0] AN1    = 8'hFD;
    localparam logic [7:0] AN2    = 8'hFB;
    localparam logic [7:0] AN3    = 8'hF7;
    localparam logic [7:0] AN_OFF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } dec_state_t;

endpackage

// File: rtl/sseg_pos_decode.sv
// Combinational map from one registered bus sample to a chase position.
// Exactly one of p_valid_o / p_blank_o / p_illegal_o is high for any input.
module sseg_pos_decode
    import sseg_pkg::*;
(
    input  logic [7:0] an_i,
    input  logic [7:0] sseg_i,
    output logic [2:0] p_o,
    output logic       p_valid_o,
    output logic       p_blank_o,
    output logic       p_illegal_o
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can leave one unassigned and infer a latch.
        p_o       = 3'd0;
        p_valid_o = 1'b0;
        p_blank_o = 1'b0;

        if (an_i == AN_OFF && sseg_i == NONE) begin
            p_blank_o = 1'b1;
        end else if (sseg_i == TOP) begin
            p_valid_o = 1'b1;
            case (an_i)
                AN0:     p_o = 3'd0;
                AN1:     p_o = 3'd1;
                AN2:     p_o = 3'd2;
                AN3:     p_o = 3'd3;
                default: p_valid_o = 1'b0;
            endcase
        end else if (sseg_i == BOT) begin
            // The bottom half of the chase runs back across the digits.
            p_valid_o = 1'b1;
            case (an_i)
                AN3:     p_o = 3'd4;
                AN2:     p_o = 3'd5;
                AN1:     p_o = 3'd6;
                AN0:     p_o = 3'd7;
                default: p_valid_o = 1'b0;
            endcase
        end

        p_illegal_o = !p_valid_o && !p_blank_o;
    end

endmodule

// File: rtl/sseg_cycle_decoder.sv
// Receive-side monitor for the segment-chase display bus: recovers position,
// direction, step pulses and lap count, and latches a sticky fault on bad patterns.
module sseg_cycle_decoder
    import sseg_pkg::*;
#(
    parameter int LAP_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [7:0]       an_i,
    input  logic [7:0]       sseg_i,
    output logic [2:0]       pos_o,
    output logic             pos_valid_o,
    output logic             dir_o,
    output logic             step_o,
    output logic [LAP_W-1:0] lap_o,
    output logic             fault_o,
    output logic             blank_o
);

    logic [7:0]       an_q, sseg_q;
    dec_state_t       state_q, state_d;
    logic [2:0]       pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic             blank_q;

    logic [2:0] p;
    logic       p_valid, p_blank, p_illegal;
    logic [2:0] delta;

    sseg_pos_decode u_decode (
        .an_i        (an_q),
        .sseg_i      (sseg_q),
        .p_o         (p),
        .p_valid_o   (p_valid),
        .p_blank_o   (p_blank),
        .p_illegal_o (p_illegal)
    );

    // 3-bit subtraction gives the forward distance mod 8 directly.
    assign delta = p - pos_q;

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            an_q    <= AN_OFF;
            sseg_q  <= NONE;
            state_q <= IDLE;
            pos_q   <= 3'd0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            lap_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            an_q    <= an_i;
            sseg_q  <= sseg_i;
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            lap_q   <= lap_d;
            blank_q <= p_blank;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        lap_d   = lap_q;

        if (clr_i) begin
            state_d = IDLE;
            lap_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p_valid) begin
                        state_d = TRACK;
                        pos_d   = p;
                    end else if (p_illegal) begin
                        state_d = FAULT;
                    end
                end
                TRACK: begin
                    if (p_illegal) begin
                        state_d = FAULT;
                    end else if (p_blank) begin
                        state_d = IDLE;
                    end else if (delta == 3'd1 || delta == 3'd7) begin
                        step_d = 1'b1;
                        dir_d  = (delta == 3'd1);
                        pos_d  = p;
                        // A wrap is a step across the 7/0 boundary in either direction.
                        if ((delta == 3'd1 && pos_q == 3'd7) || (delta == 3'd7 && pos_q == 3'd0))
                            lap_d = lap_q + LAP_W'(1);
                    end else if (delta != 3'd0) begin
                        state_d = FAULT;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    assign pos_o       = pos_q;
    assign pos_valid_o = (state_q == TRACK);
    assign dir_o       = dir_q;
    assign step_o      = step_q;
    assign lap_o       = lap_q;
    assign fault_o     = (state_q == FAULT);
    assign blank_o     = blank_q;

endmodule

// File: tb/tb_sseg_cycle_decoder.sv
// Self-checking bench: vector table, directed corner sequences, and random
// stimulus compared against a behavioural model of the monitor.
module tb_sseg_cycle_decoder;
    import sseg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clr;
    logic [7:0] an, sseg;

    logic [2:0] pos8, pos2;
    logic       valid8, dir8, step8, fault8, blank8;
    logic       valid2, dir2, step2, fault2, blank2;
    logic [7:0] lap8;
    logic [1:0] lap2;

    sseg_cycle_decoder #(.LAP_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .an_i(an), .sseg_i(sseg),
        .pos_o(pos8), .pos_valid_o(valid8), .dir_o(dir8), .step_o(step8),
        .lap_o(lap8), .fault_o(fault8), .blank_o(blank8)
    );

    sseg_cycle_decoder #(.LAP_W(2)) dut_lap2 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .an_i(an), .sseg_i(sseg),
        .pos_o(pos2), .pos_valid_o(valid2), .dir_o(dir2), .step_o(step2),
        .lap_o(lap2), .fault_o(fault2), .blank_o(blank2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus encoding of chase position p, as {an, sseg}.
    function automatic logic [15:0] pat(input int p);
        logic [7:0] a;
        a = 8'hFF;
        if (p < 4) begin
            a[p] = 1'b0;
            return {a, TOP};
        end
        a[7 - p] = 1'b0;
        return {a, BOT};
    endfunction

    // Reference model: 0..7 position, 8 blank, 9 illegal.
    function automatic int model_decode(input logic [7:0] a, input logic [7:0] s);
        for (int p = 0; p < 8; p++)
            if (pat(p) == {a, s}) return p;
        if (a == 8'hFF && s == 8'hFF) return 8;
        return 9;
    endfunction

    logic [7:0] m_an, m_seg;
    bit m_track, m_fault;
    int m_pos, m_dir, m_step, m_lap, m_blank;

    task automatic model_edge(input logic [7:0] a, input logic [7:0] s, input bit c, input bit r);
        int sym;
        int d;
        if (!r) begin
            m_an = 8'hFF; m_seg = 8'hFF;
            m_track = 0; m_fault = 0;
            m_pos = 0; m_dir = 1; m_step = 0; m_lap = 0; m_blank = 0;
            return;
        end
        sym = model_decode(m_an, m_seg);
        m_step = 0;
        m_blank = (sym == 8) ? 1 : 0;
        if (c) begin
            m_track = 0; m_fault = 0; m_lap = 0;
        end else if (m_fault) begin
            m_fault = 1;
        end else if (sym == 9) begin
            m_fault = 1; m_track = 0;
        end else if (sym == 8) begin
            m_track = 0;
        end else if (!m_track) begin
            m_track = 1; m_pos = sym;
        end else begin
            d = (sym - m_pos + 8) % 8;
            if (d == 1 || d == 7) begin
                m_step = 1;
                m_dir = (d == 1) ? 1 : 0;
                if ((d == 1 && sym == 0) || (d == 7 && sym == 7)) m_lap = (m_lap + 1) % 256;
                m_pos = sym;
            end else if (d != 0) begin
                m_fault = 1; m_track = 0;
            end
        end
        m_an = a; m_seg = s;
    endtask

    task automatic cyc(input logic [7:0] a, input logic [7:0] s, input bit c, input bit r);
        an = a; sseg = s; clr = c; rst_n = r;
        @(posedge clk);
        model_edge(a, s, c, r);
        #1;
    endtask

    task automatic drive_pos(input int p, input bit c);
        logic [15:0] v;
        v = pat(p);
        cyc(v[15:8], v[7:0], c, 1'b1);
    endtask

    task automatic drive_blank();
        cyc(8'hFF, 8'hFF, 1'b0, 1'b1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".pos"},   32'(pos8),   0);
        check({tag, ".valid"}, 32'(valid8), 0);
        check({tag, ".dir"},   32'(dir8),   1);
        check({tag, ".step"},  32'(step8),  0);
        check({tag, ".lap"},   32'(lap8),   0);
        check({tag, ".fault"}, 32'(fault8), 0);
        check({tag, ".blank"}, 32'(blank8), 0);
    endtask

    task automatic compare_model(input int n);
        check($sformatf("rnd%0d.pos", n),   32'(pos8),   32'(m_pos));
        check($sformatf("rnd%0d.valid", n), 32'(valid8), 32'(m_track));
        check($sformatf("rnd%0d.dir", n),   32'(dir8),   32'(m_dir));
        check($sformatf("rnd%0d.step", n),  32'(step8),  32'(m_step));
        check($sformatf("rnd%0d.lap", n),   32'(lap8),   32'(m_lap));
        check($sformatf("rnd%0d.lap2", n),  32'(lap2),   32'(m_lap % 4));
        check($sformatf("rnd%0d.fault", n), 32'(fault8), 32'(m_fault));
        check($sformatf("rnd%0d.blank", n), 32'(blank8), 32'(m_blank));
    endtask

    typedef struct {
        int p;
        bit clr;
        int pos, valid, dir, step, lap, fault, blank;
    } vec_t;

    function automatic vec_t mk(input int p, input bit c, input int ps, input int v, input int d,
                                input int st, input int l, input int f, input int b);
        vec_t x;
        x.p = p; x.clr = c; x.pos = ps; x.valid = v; x.dir = d;
        x.step = st; x.lap = l; x.fault = f; x.blank = b;
        return x;
    endfunction

    initial begin
        vec_t vt[14];
        int   steps;
        int   wraps[$];
        int   cur;
        int   r;
        bit   c;
        bit   rs;

        // Expected outputs in row i reflect the bus driven in row i-1.
        vt[0]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1);
        vt[1]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0);
        vt[2]  = mk(2, 0, 1, 1, 1, 1, 0, 0, 0);
        vt[3]  = mk(3, 0, 2, 1, 1, 1, 0, 0, 0);
        vt[4]  = mk(4, 0, 3, 1, 1, 1, 0, 0, 0);
        vt[5]  = mk(5, 0, 4, 1, 1, 1, 0, 0, 0);
        vt[6]  = mk(6, 0, 5, 1, 1, 1, 0, 0, 0);
        vt[7]  = mk(7, 0, 6, 1, 1, 1, 0, 0, 0);
        vt[8]  = mk(0, 0, 7, 1, 1, 1, 0, 0, 0);
        vt[9]  = mk(0, 0, 0, 1, 1, 1, 1, 0, 0);
        vt[10] = mk(0, 0, 0, 1, 1, 0, 1, 0, 0);
        vt[11] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0);
        vt[12] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0);
        vt[13] = mk(1, 0, 1, 1, 1, 1, 0, 0, 0);

        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        reset_checks("reset");

        // Forward chase plus clear, from the vector table.
        for (int i = 0; i < 14; i++) begin
            drive_pos(vt[i].p, vt[i].clr);
            check($sformatf("vec%0d.pos", i),   32'(pos8),   32'(vt[i].pos));
            check($sformatf("vec%0d.valid", i), 32'(valid8), 32'(vt[i].valid));
            check($sformatf("vec%0d.dir", i),   32'(dir8),   32'(vt[i].dir));
            check($sformatf("vec%0d.step", i),  32'(step8),  32'(vt[i].step));
            check($sformatf("vec%0d.lap", i),   32'(lap8),   32'(vt[i].lap));
            check($sformatf("vec%0d.fault", i), 32'(fault8), 32'(vt[i].fault));
            check($sformatf("vec%0d.blank", i), 32'(blank8), 32'(vt[i].blank));
        end

        // Reverse chase through the 0->7 wrap, then reset mid-operation.
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        steps = 0;
        foreach (vt[i]) if (i < 8) begin
            drive_pos((i < 6) ? (3 - i + 8) % 8 : 6, 1'b0);
            steps += int'(step8);
        end
        check("rev.steps", 32'(steps), 5);
        check("rev.dir",   32'(dir8),  0);
        check("rev.lap",   32'(lap8),  1);
        check("rev.pos",   32'(pos8),  6);
        check("rev.fault", 32'(fault8), 0);
        drive_pos(6, 1'b0);
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        reset_checks("rev_rst");
        drive_pos(6, 1'b0);
        check("rev_rst.flush_valid", 32'(valid8), 0);

        // Hold, blank, and adjacent re-entry without a step.
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        steps = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 5) drive_pos(2, 1'b0);
            else if (i < 8) drive_blank();
            else drive_pos(3, 1'b0);
            steps += int'(step8);
            if (i >= 6 && i <= 8) begin
                check($sformatf("blank%0d.valid", i), 32'(valid8), 0);
                check($sformatf("blank%0d.blank", i), 32'(blank8), 1);
            end
            if (i == 9) begin
                check("reentry.pos",   32'(pos8),   3);
                check("reentry.valid", 32'(valid8), 1);
                check("reentry.step",  32'(step8),  0);
            end
        end
        check("hold.steps", 32'(steps), 0);

        // Jump fault with a nonzero lap, sticky until clr.
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        drive_pos(6, 1'b0); drive_pos(7, 1'b0); drive_pos(0, 1'b0);
        drive_pos(1, 1'b0); drive_pos(4, 1'b0); drive_pos(5, 1'b0);
        check("jump.fault", 32'(fault8), 1);
        check("jump.valid", 32'(valid8), 0);
        check("jump.pos",   32'(pos8),   1);
        check("jump.lap",   32'(lap8),   1);
        drive_pos(5, 1'b0);
        check("jump.sticky", 32'(fault8), 1);
        drive_pos(5, 1'b1);
        check("clr.fault", 32'(fault8), 0);
        check("clr.lap",   32'(lap8),   0);
        check("clr.valid", 32'(valid8), 0);
        check("clr.pos",   32'(pos8),   1);

        // Illegal patterns.
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        cyc(8'hFC, TOP, 1'b0, 1'b1);
        check("ill_two.early", 32'(fault8), 0);
        drive_pos(0, 1'b0);
        check("ill_two.fault", 32'(fault8), 1);
        cyc(8'hFE, TOP, 1'b0, 1'b0);
        reset_checks("ill_rst");
        cyc(8'h7E, TOP, 1'b0, 1'b1);
        drive_pos(0, 1'b0);
        check("ill_hi_nibble.fault", 32'(fault8), 1);
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        cyc(AN1, NONE, 1'b0, 1'b1);
        drive_pos(1, 1'b0);
        check("ill_anode_none.fault", 32'(fault8), 1);

        // Lap wrap on the 2-bit counter over five forward revolutions.
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        drive_pos(0, 1'b0);
        for (int n = 0; n < 41; n++) begin
            drive_pos((n < 40) ? (n + 1) % 8 : 0, 1'b0);
            if (step2 && pos2 == 3'd0) wraps.push_back(int'(lap2));
        end
        check("lap2.count", 32'(wraps.size()), 5);
        if (wraps.size() == 5) begin
            check("lap2.w0", 32'(wraps[0]), 1);
            check("lap2.w1", 32'(wraps[1]), 2);
            check("lap2.w2", 32'(wraps[2]), 3);
            check("lap2.w3", 32'(wraps[3]), 0);
            check("lap2.w4", 32'(wraps[4]), 1);
        end
        check("lap8.total", 32'(lap8), 5);

        // Random traffic against the reference model.
        cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
        cur = 0;
        for (int n = 0; n < 3000; n++) begin
            r  = int'($urandom_range(0, 99));
            c  = ($urandom_range(0, 99) < 4);
            rs = !($urandom_range(0, 99) < 1);
            if (r < 3) begin
                cyc(8'($urandom), 8'($urandom), c, rs);
            end else if (r < 8) begin
                cyc(8'hFF, 8'hFF, c, rs);
            end else begin
                if (r < 12) cur = (cur + int'($urandom_range(2, 6))) % 8;
                else if (r < 20) cur = cur;
                else if (r < 60) cur = (cur + 1) % 8;
                else cur = (cur + 7) % 8;
                begin
                    logic [15:0] v;
                    v = pat(cur);
                    cyc(v[15:8], v[7:0], c, rs);
                end
            end
            compare_model(n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sseg_cycle_decoder.md
# sseg_cycle_decoder

Receive-side monitor for the four-digit segment-chase display bus. Samples the multiplexed `an`/`sseg` lines and recovers the chase position (0–7), rotation direction, step pulses and lap count. Flags illegal or non-adjacent patterns. Sits on the board-level loopback / self-check path beside the display driver, fed from the same `an`/`sseg` nets.

## Interface
- `LAP_W`, default 8: lap counter width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `clr`  in  1  synchronous clear of fault, lap and tracking; active-high.
- `an`  in  8  sampled anode bus, active-low.
- `sseg`  in  8  sampled segment bus, active-low.
- `pos`  out  3  last accepted chase position.
- `pos_valid`  out  1  `pos` is current (state TRACK).
- `dir`  out  1  direction of last step: 1 = forward (0→1→…→7), 0 = reverse.
- `step`  out  1  one-cycle pulse per accepted adjacent step.
- `lap`  out  LAP_W  count of wraps 7→0 or 0→7.
- `fault`  out  1  sticky; illegal pattern or jump seen.
- `blank`  out  1  bus currently blank.

## Operation
- Input stage: `an`, `sseg` are registered once (`an_q`, `sseg_q`) before decode.
- Decode of the registered bus:
  - pattern TOP = 8'b10011100, BOT = 8'b10100011, NONE = 8'hFF.
  - anode codes AN0..AN3 = 8'hFE, 8'hFD, 8'hFB, 8'hF7; all-off = 8'hFF.
  - TOP + AN0..AN3 → positions 0..3.
  - BOT + AN3, AN2, AN1, AN0 → positions 4..7.
  - NONE + all-off → blank.
  - Anything else → illegal, including one anode on with NONE segments, and `an[7:4]` ≠ 4'hF.
- FSM states: IDLE, TRACK, FAULT.
  - IDLE:
    - valid position p → TRACK, `pos`=p, no step.
    - blank → stay IDLE.
    - illegal → FAULT.
  - TRACK, with d = (p − pos) mod 8:
    - d = 0: hold.
    - d = 1: `step`=1, `dir`=1, `pos`=p.
    - d = 7: `step`=1, `dir`=0, `pos`=p.
    - any other d: jump → FAULT.
    - blank → IDLE.
    - illegal → FAULT.
  - FAULT: holds regardless of bus; exit only via `clr` or `rst` → IDLE.
- `lap` increments (mod 2^LAP_W) on a forward step 7→0 and on a reverse step 0→7.
- `pos_valid` = (state == TRACK).
- `fault` = (state == FAULT).
- `pos` holds its last value in IDLE and FAULT.
- `blank` = registered decode of blank, independent of state.

## Timing
- Reset (`rst`=0 at edge), all outputs:
  - state IDLE, `pos`=0, `pos_valid`=0, `dir`=1, `step`=0, `lap`=0, `fault`=0, `blank`=0.
  - input registers load 8'hFF.
- Latency: a bus change at edge k is visible on `pos`/`step`/`fault` after edge k+2 (input stage + state register).
- `blank` latency is also 2 cycles.
- `step` is high exactly one cycle per accepted move. A bus advancing every cycle yields `step` high continuously.
- `clr` priority:
  - `clr` beats decode in the same cycle: state IDLE, `lap`=0, `fault`=0, `step`=0.
  - `pos` and `dir` are unchanged.
  - Input registers keep sampling.
- `rst` priority: `rst` beats `clr`. Reset mid-operation discards the in-flight sample.
- Blank→valid re-entry never produces `step`, even when adjacent to the held `pos`.
- Direction reversal (d=7 after d=1) is a legal step. It updates `dir` with no fault.

## Structure
- Package `sseg_pkg` holds:
  - pattern constants TOP, BOT, NONE;
  - anode constants AN0..AN3 and AN_OFF;
  - enum `dec_state_t` {IDLE, TRACK, FAULT}.
- Sub-module `sseg_pos_decode`: purely combinational, maps (`an_q`, `sseg_q`) → `p[2:0]`, `p_valid`, `p_blank`, `p_illegal`.
- Top module holds the input registers, FSM, step/dir logic and lap counter.

## Test plan
- Forward chase:
  - Stimulus: drive positions 0..7 then 0, one per cycle, after reset.
  - Required: `pos_valid` rises 2 cycles after first sample, 8 `step` pulses, `dir`=1, `lap`=1, `fault`=0.
- Reverse chase:
  - Stimulus: drive 3,2,1,0,7,6.
  - Required: 5 steps, `dir`=0, `lap`=1, final `pos`=6.
- Hold and blank:
  - Stimulus: hold position 2 for 5 cycles, then NONE/8'hFF for 3 cycles, then position 3.
  - Required: no step while holding; `pos_valid`=0 and `blank`=1 during blank; re-entry `pos`=3 with no step.
- Jump fault:
  - Stimulus: position 1 then position 4.
  - Required: `fault`=1, `pos_valid`=0, `pos`=1 held.
  - Required: further legal patterns leave `fault`=1 until `clr` pulse → `fault`=0, `lap`=0.
- Illegal pattern:
  - Stimulus: `an`=8'hFC (two digits on) with TOP.
  - Required: FAULT 2 cycles later.
  - Stimulus: then `rst`=0 for one edge.
  - Required: all outputs at reset values.
- Lap wrap:
  - Setup: `LAP_W`=2.
  - Stimulus: 5 forward revolutions.
  - Required: `lap` sequence 1,2,3,0,1.
